// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// State encoding, idle line level and bit-counter sizing.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic IDLE_BIT_DEF = 1'b0;

    // Bit counter must hold PAT_W-1; never narrower than one bit.
    function automatic int bit_cnt_w(input int pat_w);
        return (pat_w > 2) ? $clog2(pat_w) : 1;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out register, MSB first; load has priority over shift.
// Zero latency from register to o_msb; no flow control, shifts when told.
module piso_shift #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [PAT_W-1:0] i_dat,
    output logic             o_msb
);

    logic [PAT_W-1:0] r_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_dat;
        end else if (i_shift) begin
            r_sh <= {r_sh[PAT_W-2:0], 1'b0};
        end
    end

    assign o_msb = r_sh[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: repeats a captured pattern MSB-first with idle gaps.
// First bit appears one cycle after start is accepted in IDLE; start is ignored otherwise.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 4,
    parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [CNT_W-1:0] gap_n,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int              BCW      = bit_cnt_w(PAT_W);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(PAT_W - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PAT_W-1:0] r_pat;
    logic [CNT_W-1:0] r_rep;
    logic [CNT_W-1:0] r_gap;
    logic [CNT_W-1:0] r_copy_cnt;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [BCW-1:0]   r_bit_cnt;

    logic             w_capture;
    logic             w_load;
    logic             w_shift;
    logic             w_bit_clr;
    logic             w_bit_inc;
    logic             w_copy_inc;
    logic             w_gap_ld;
    logic             w_gap_dec;
    logic [PAT_W-1:0] w_pat_src;
    logic             w_msb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Copy counter is compared before incrementing, so it never exceeds r_rep.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_bit_clr   = 1'b0;
        w_bit_inc   = 1'b0;
        w_copy_inc  = 1'b0;
        w_gap_ld    = 1'b0;
        w_gap_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                    w_capture   = 1'b1;
                    w_load      = 1'b1;
                    w_bit_clr   = 1'b1;
                end
            end
            SHIFT: begin
                if (r_bit_cnt == LAST_BIT) begin
                    if (r_copy_cnt == r_rep) begin
                        w_state_nxt = DONE;
                    end else if (r_gap == '0) begin
                        w_load     = 1'b1;
                        w_copy_inc = 1'b1;
                        w_bit_clr  = 1'b1;
                    end else begin
                        w_state_nxt = GAP;
                        w_gap_ld    = 1'b1;
                    end
                end else begin
                    w_shift   = 1'b1;
                    w_bit_inc = 1'b1;
                end
            end
            GAP: begin
                if (r_gap_cnt == CNT_W'(1)) begin
                    w_state_nxt = SHIFT;
                    w_load      = 1'b1;
                    w_copy_inc  = 1'b1;
                    w_bit_clr   = 1'b1;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat      <= '0;
            r_rep      <= '0;
            r_gap      <= '0;
            r_copy_cnt <= '0;
            r_gap_cnt  <= '0;
            r_bit_cnt  <= '0;
        end else begin
            if (w_capture) begin
                r_pat      <= pattern;
                r_rep      <= repeat_n;
                r_gap      <= gap_n;
                r_copy_cnt <= '0;
            end else if (w_copy_inc) begin
                r_copy_cnt <= r_copy_cnt + CNT_W'(1);
            end
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
            if (w_gap_ld) begin
                r_gap_cnt <= r_gap;
            end else if (w_gap_dec) begin
                r_gap_cnt <= r_gap_cnt - CNT_W'(1);
            end
        end
    end

    assign w_pat_src = (r_state == IDLE) ? pattern : r_pat;

    piso_shift #(
        .PAT_W (PAT_W)
    ) u_piso (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_dat   (w_pat_src),
        .o_msb   (w_msb)
    );

    assign out         = (r_state == SHIFT) ? w_msb : IDLE_BIT;
    assign out_valid   = (r_state == SHIFT) || (r_state == GAP);
    assign frame_start = (r_state == SHIFT) && (r_bit_cnt == '0);
    assign busy        = (r_state == SHIFT) || (r_state == GAP);
    assign done        = (r_state == DONE);

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the transmit end of the block's bit-serial sequence-detection path.
- Loads a PAT_W-bit pattern and shifts it out MSB-first, one bit per clock.
- Repeats the pattern a programmable number of times, with a programmable idle gap between copies.
- Drives the 1010 Moore detector and similar detectors, both in system and in loopback test.

Parameters:
- PAT_W, 4, pattern width in bits (min 2)
- CNT_W, 4, width of the repeat count and the gap count
- IDLE_BIT, 1'b0, value driven on out when not sending pattern bits

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- pattern  input  PAT_W  pattern to send; captured when start is accepted
- repeat_n  input  CNT_W  extra copies after the first (total copies = repeat_n+1); captured on start
- gap_n  input  CNT_W  idle cycles between copies; captured on start
- out  output  1  serial data, registered
- out_valid  output  1  high on every cycle of a pattern bit or gap bit
- frame_start  output  1  high during the first (MSB) bit of each copy
- busy  output  1  high from the cycle after start acceptance until done
- done  output  1  one-cycle pulse after the last bit of the last copy

Behaviour:
- Clock and reset: clk is the clock. reset is asynchronous, active-high.
- Reset values: state=IDLE, out=IDLE_BIT, out_valid=0, frame_start=0, busy=0, done=0, all counters 0.
- Moore FSM, states IDLE, SHIFT, GAP, DONE. Every output is a registered function of state and datapath.
- IDLE:
  - If start=1 at edge E0: capture pattern/repeat_n/gap_n into the shift register and counters, go to SHIFT.
  - Starting in the cycle after E0: busy=1, out=pattern[PAT_W-1], out_valid=1, frame_start=1.
- SHIFT:
  - Each edge shifts left; bit counter increments.
  - After PAT_W bits (the last bit is driven in the cycle before the transition):
    - If the copy counter equals the captured repeat_n, go to DONE.
    - Else if gap_n=0, reload the shift register from the captured pattern, increment the copy counter, stay in SHIFT. The next copy starts with no bubble and frame_start=1.
    - Else go to GAP.
- GAP:
  - out=IDLE_BIT, out_valid=1, frame_start=0, for exactly gap_n cycles.
  - Then reload the pattern, increment the copy counter, go to SHIFT.
- DONE:
  - One cycle: done=1, busy=0, out=IDLE_BIT, out_valid=0. Unconditionally returns to IDLE.
- Latency: start edge to first bit = 1 cycle. Total valid cycles = (repeat_n+1)*PAT_W + repeat_n*gap_n.
- Boundary conditions:
  - start while busy or in DONE: ignored, never queued.
  - pattern, repeat_n, gap_n changing while busy: no effect, because only captured copies are used.
  - repeat_n at max (all ones): 2^CNT_W copies sent; the copy counter must not wrap early (counter width CNT_W+1 or compare-before-increment).
  - gap_n=0: copies back-to-back; frame_start every PAT_W cycles.
  - reset mid-SHIFT or mid-GAP: immediate return to reset values, no done pulse. The next start after reset release behaves as from power-up.
  - start held high continuously: a new transmission begins on the edge after DONE, i.e. the IDLE edge.

Decomposition:
- Package seq_pkg:
  - FSM state type/encoding (IDLE, SHIFT, GAP, DONE)
  - IDLE_BIT default
  - helper constant for bit-counter width, $clog2(PAT_W)
- Sub-module piso_shift: parallel-in serial-out register, PAT_W wide, with load, shift enable, and MSB output. The FSM and counters stay in seq_pattern_tx.

Test Plan:
- Single copy: reset, then start=1 for one cycle with pattern=4'b1010, repeat_n=0, gap_n=0.
  -> out=1,0,1,0 on cycles 1-4 with out_valid=1; frame_start only on cycle 1; done=1 on cycle 5; busy high on cycles 1-4.
- Repeats with gap: pattern=1010, repeat_n=2, gap_n=2.
  -> out = 1010 00 1010 00 1010, 16 valid cycles; frame_start on cycles 1, 7, 13; done on cycle 17.
- Back-to-back copies: pattern=1101, repeat_n=1, gap_n=0.
  -> 8 contiguous valid bits 11011101; frame_start on cycles 1 and 5.
- Ignored inputs while busy: re-pulse start and change pattern to 0110 on cycle 2 of a 1010 transmission.
  -> output unchanged from the 1010 sequence; exactly one done pulse.
- Reset mid-operation: assert reset on cycle 3 of a transmission.
  -> all outputs go to reset values asynchronously; no done pulse; a fresh start after release yields the full sequence from the MSB.
- Loopback: pattern=1010, repeat_n=3, gap_n=1, out driving the 1010 Moore detector.
  -> the detector flags exactly 4 detections, one after each copy.
